uart_tx_block: RTL
==================

Name: uart_tx_block

Overview:
Serial transmitter that drives the asynchronous serial line sampled at the far end by the receive path's input synchronizer and receiver.
- Accepts a parallel byte through a start handshake.
- Emits an idle-high UART frame: start bit, data bits LSB first, stop bit. Each bit is held for a programmable number of clocks.
- Sits between the local packet/FIFO logic and the chip's serial output pad.

Parameters:
CLKS_PER_BIT, 10, clock cycles each serial bit is held; legal range 2..1023
DATA_BITS, 8, data bits per frame; legal range 5..8

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
tx_start  input  1  request to transmit tx_data; sampled only in IDLE
tx_data  input  DATA_BITS  byte to send; captured on the accepting edge
serial_out  output  1  serial line, registered, idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse after stop bit completes

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - serial_out=1, tx_busy=0, tx_done=0.
  - Internal state=IDLE; bit timer=0, bit index=0, shift register=0.
  - Asserting rst mid-frame forces serial_out high immediately, without waiting for a clock edge. The frame is abandoned and no tx_done is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- IDLE:
  - serial_out=1, tx_busy=0.
  - On an edge with tx_start=1: latch tx_data into the shift register, clear the timer, go to START.
  - From that edge on, serial_out=0 and tx_busy=1.
- START: serial_out=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - serial_out = shift register bit 0.
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After bit DATA_BITS-1 completes, go to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles. On the final edge: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Wraps to 0 on each bit boundary; it must never reach CLKS_PER_BIT.
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles from the accepting edge to the edge that raises tx_done.
- Handshake rules:
  - tx_start while tx_busy=1 is ignored; it is not queued.
  - tx_data changes while busy have no effect on the frame in progress.
- Back-to-back frames:
  - tx_start may be high in the tx_done cycle. It is accepted on the next edge, giving a minimum of 1 idle-high cycle between the stop bit and the next start bit.
  - tx_start held continuously produces consecutive frames, each separated by exactly one extra idle cycle.
- X on tx_data at the accepting edge propagates to serial_out. No masking is done; the bench must not drive X at acceptance.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - serial_out = even parity (XOR of the DATA_BITS captured bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined:
  - No parity state, no parity logic.
  - Frame is start + data + stop only.

Test Plan:
- Reset: assert rst for 2 cycles, with tx_start=1 and tx_data=8'hFF during reset -> serial_out=1, tx_busy=0, tx_done=0 throughout; no frame starts after release until tx_start is re-sampled in IDLE.
- Single frame, CLKS_PER_BIT=10, tx_data=8'hA5 -> bits sampled at cycle offsets 5,15,...,95 read 0,1,0,1,0,0,1,0,1,1; tx_done pulses for one cycle exactly 100 cycles after the accepting edge; tx_busy high for cycles 0..99.
- Ignore while busy: pulse tx_start with tx_data=8'h3C at cycle 40 of an 8'h0F frame -> the frame still carries 8'h0F; no second frame follows tx_done.
- Back-to-back: hold tx_start=1 with tx_data=8'h00, then 8'hFF -> two frames; exactly 1 idle-high cycle between the first stop bit end and the second start bit; two tx_done pulses 101 cycles apart.
- Reset mid-frame: assert rst at cycle 37 of a frame -> serial_out=1 before the next clock edge; no tx_done; after release, a new 8'h81 frame transmits correctly.
- Parity (UART_TX_PARITY_EN defined), tx_data=8'hA5 -> parity bit at offset 95 = 0, stop bit at offset 105 = 1; tx_data=8'h07 -> parity = 1; tx_done at cycle 110.

Source files
------------

// File: rtl/uart_tx_block.sv
// uart_tx_block: idle-high UART transmitter (start bit, DATA_BITS data bits
// sent LSB first, stop bit). Every bit is held for CLKS_PER_BIT clocks.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
// All outputs come straight from flops. Because serial_out sits on the async
// reset, rst drives the line high at once, with no wait for a clock edge.
module uart_tx_block #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] INDEX_ZERO = IW'(0);
  localparam logic [IW-1:0] INDEX_ONE  = IW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity over the whole captured word: the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t               state_r, state_s;
  logic [TW-1:0]        timer_r, timer_s;
  logic [IW-1:0]        index_r, index_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 serial_r, serial_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r, parity_s;
`endif

  // State and datapath registers. Reset returns the block to idle with the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      timer_r  <= TIMER_ZERO;
      index_r  <= INDEX_ZERO;
      shift_r  <= {DATA_BITS{1'b0}};
      serial_r <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      index_r  <= index_s;
      shift_r  <= shift_s;
      serial_r <= serial_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef UART_TX_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Next state, bit timing and shifting. The output values are computed from
  // the next state so the registered outputs line up with the state register.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    index_s = index_r;
    shift_s = shift_r;
    done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      S_IDLE: begin
        timer_s = TIMER_ZERO;
        index_s = INDEX_ZERO;
        if (tx_start) begin
          state_s = S_START;
          shift_s = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_s = even_parity(tx_data);
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (timer_r == TIMER_LAST) begin
          state_s = S_DATA;
          timer_s = TIMER_ZERO;
          index_s = INDEX_ZERO;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
      S_DATA: begin
        if (timer_r == TIMER_LAST) begin
          timer_s = TIMER_ZERO;
          shift_s = shift_r >> 1'b1;
          if (index_r == INDEX_LAST) begin
            index_s = INDEX_ZERO;
`ifdef UART_TX_PARITY_EN
            state_s = S_PARITY;
`else
            state_s = S_STOP;
`endif
          end else begin
            index_s = index_r + INDEX_ONE;
          end
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_r == TIMER_LAST) begin
          state_s = S_STOP;
          timer_s = TIMER_ZERO;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
`endif
      S_STOP: begin
        if (timer_r == TIMER_LAST) begin
          state_s = S_IDLE;
          timer_s = TIMER_ZERO;
          done_s  = 1'b1;
        end else begin
          timer_s = timer_r + TIMER_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        timer_s = TIMER_ZERO;
        index_s = INDEX_ZERO;
      end
    endcase

    busy_s = (state_s != S_IDLE);

    case (state_s)
      S_IDLE:   serial_s = 1'b1;
      S_START:  serial_s = 1'b0;
      S_DATA:   serial_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_s = parity_s;
`endif
      S_STOP:   serial_s = 1'b1;
      default:  serial_s = 1'b1;
    endcase
  end

  assign serial_out = serial_r;
  assign tx_busy    = busy_r;
  assign tx_done    = done_r;

endmodule
